spi_peripheral_sp3a_model: RTL and testbench

FPGA-side SPI responder model of the SP3A register-file peripheral, the far end of the SP3A SPI initiator. It decodes the framed header (address, opcode group, WE, zero bit), then captures write data into an internal banked register file or serialises stored data back on `poci`. It is used for on-board loopback bring-up of the SP3A controller path without silicon. It runs on `axi_clk`, which is also the SPI bit clock.

---
 rtl/sp3a_spi_pkg.sv | 26 ++
 rtl/sp3a_reg_bank.sv | 44 ++++
 rtl/spi_peripheral_sp3a_model.sv | 158 +++++++++++++++
 tb/tb_spi_peripheral_sp3a_model.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sp3a_spi_pkg.sv
// Shared state encoding, header geometry and address-range helper for the
// SP3A SPI responder model.
package sp3a_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ADDR,
        ST_GROUP,
        ST_WE,
        ST_ZERO,
        ST_WDATA,
        ST_RDATA
    } state_t;

    localparam int SETUP_BITS = 2;
    localparam int ADDR_BITS  = 8;
    localparam int GROUP_BITS = 2;
    localparam int NUM_GROUPS = 4;

    function automatic logic addr_in_range(input logic [ADDR_BITS-1:0] addr,
                                           input int num_regs);
        return ({{(32-ADDR_BITS){1'b0}}, addr} < 32'(num_regs));
    endfunction

endpackage

// File: rtl/sp3a_reg_bank.sv
// Banked register file: one write port, a serial-read port and a backdoor
// read port, both combinational and returning 0 for out-of-range addresses.
module sp3a_reg_bank
    import sp3a_spi_pkg::*;
#(
    parameter int REG_WIDTH = 32,
    parameter int NUM_REGS  = 16
) (
    input  logic                  axi_clk,
    input  logic                  reset_b,
    input  logic                  i_we,
    input  logic [GROUP_BITS-1:0] i_wgroup,
    input  logic [ADDR_BITS-1:0]  i_waddr,
    input  logic [REG_WIDTH-1:0]  i_wdata,
    input  logic [GROUP_BITS-1:0] i_sgroup,
    input  logic [ADDR_BITS-1:0]  i_saddr,
    output logic [REG_WIDTH-1:0]  o_sdata,
    input  logic [GROUP_BITS-1:0] i_bgroup,
    input  logic [ADDR_BITS-1:0]  i_baddr,
    output logic [REG_WIDTH-1:0]  o_bdata
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [REG_WIDTH-1:0] r_mem [NUM_GROUPS][NUM_REGS];

    always_ff @(posedge axi_clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int g = 0; g < NUM_GROUPS; g++) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    r_mem[g][r] <= '0;
                end
            end
        end else if (i_we && addr_in_range(i_waddr, NUM_REGS)) begin
            r_mem[i_wgroup][i_waddr[IDX_W-1:0]] <= i_wdata;
        end
    end

    assign o_sdata = addr_in_range(i_saddr, NUM_REGS) ?
                     r_mem[i_sgroup][i_saddr[IDX_W-1:0]] : '0;
    assign o_bdata = addr_in_range(i_baddr, NUM_REGS) ?
                     r_mem[i_bgroup][i_baddr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/spi_peripheral_sp3a_model.sv
// SP3A SPI responder: decodes the 14-bit frame header, then streams write
// words into the register bank or serialises register words back on poci.
module spi_peripheral_sp3a_model
    import sp3a_spi_pkg::*;
#(
    parameter int REG_WIDTH = 32,
    parameter int NUM_REGS  = 16
) (
    input  logic                 axi_clk,
    input  logic                 reset_b,
    input  logic                 cs_b,
    input  logic                 pico,
    output logic                 poci,
    input  logic [1:0]           bd_group,
    input  logic [7:0]           bd_addr,
    output logic [REG_WIDTH-1:0] bd_rdata,
    output logic                 wr_strobe,
    output logic                 frame_done,
    output logic                 frame_abort
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [4:0]            r_cnt;
    logic                  w_cnt_last;
    logic [ADDR_BITS-1:0]  r_addr;
    logic [GROUP_BITS-1:0] r_group;
    logic                  r_we;
    logic [REG_WIDTH-2:0]  r_ishift;
    logic [REG_WIDTH-1:0]  r_oshift;
    logic                  r_wr_strobe;
    logic                  r_frame_done;
    logic                  r_frame_abort;

    logic                  w_frame_end;
    logic                  w_abort;
    logic                  w_commit;
    logic                  w_reload;
    logic [ADDR_BITS-1:0]  w_rd_addr;
    logic [REG_WIDTH-1:0]  w_rd_data;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_last  = 1'b0;
        case (r_state)
            ST_SETUP:           w_cnt_last = (r_cnt == 5'(SETUP_BITS-1));
            ST_ADDR:            w_cnt_last = (r_cnt == 5'(ADDR_BITS-1));
            ST_GROUP:           w_cnt_last = (r_cnt == 5'(GROUP_BITS-1));
            ST_WE, ST_ZERO:     w_cnt_last = 1'b1;
            ST_WDATA, ST_RDATA: w_cnt_last = (r_cnt == 5'(REG_WIDTH-1));
            default:            w_cnt_last = 1'b0;
        endcase

        if (r_state != ST_IDLE && cs_b) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (!cs_b)     w_state_nxt = ST_SETUP;
                ST_SETUP: if (w_cnt_last) w_state_nxt = ST_ADDR;
                ST_ADDR:  if (w_cnt_last) w_state_nxt = ST_GROUP;
                ST_GROUP: if (w_cnt_last) w_state_nxt = ST_WE;
                ST_WE:    w_state_nxt = ST_ZERO;
                ST_ZERO:  w_state_nxt = r_we ? ST_WDATA : ST_RDATA;
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    assign w_frame_end = cs_b && (r_state != ST_IDLE);
    assign w_abort     = w_frame_end &&
                         ((r_state inside {ST_SETUP, ST_ADDR, ST_GROUP, ST_WE, ST_ZERO}) ||
                          (r_state == ST_WDATA && r_cnt != 5'd0));
    assign w_commit    = !cs_b && (r_state == ST_WDATA) && w_cnt_last;
    assign w_reload    = !cs_b && (r_state == ST_RDATA) && w_cnt_last;
    // During RDATA the next word is prefetched so the reload edge has no gap bit.
    assign w_rd_addr   = (r_state == ST_RDATA) ? r_addr + 8'd1 : r_addr;

    always_ff @(posedge axi_clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge axi_clk or negedge reset_b) begin
        if (!reset_b) begin
            r_cnt         <= 5'd0;
            r_oshift      <= '0;
            r_wr_strobe   <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_abort <= 1'b0;
        end else begin
            // The IDLE->SETUP edge already carries setup bit 0.
            if (r_state == ST_IDLE) begin
                r_cnt <= 5'd1;
            end else if (w_state_nxt != r_state || w_cnt_last) begin
                r_cnt <= 5'd0;
            end else begin
                r_cnt <= r_cnt + 5'd1;
            end

            if (w_state_nxt == ST_RDATA) begin
                if (r_state == ST_ZERO || w_reload) begin
                    r_oshift <= w_rd_data;
                end else begin
                    r_oshift <= {r_oshift[REG_WIDTH-2:0], 1'b0};
                end
            end else begin
                r_oshift <= '0;
            end

            r_wr_strobe   <= w_commit && addr_in_range(r_addr, NUM_REGS);
            r_frame_done  <= w_frame_end && !w_abort;
            r_frame_abort <= w_abort;
        end
    end

    always_ff @(posedge axi_clk) begin
        if (!cs_b) begin
            case (r_state)
                ST_ADDR:  r_addr  <= {r_addr[ADDR_BITS-2:0], pico};
                ST_GROUP: r_group <= {r_group[GROUP_BITS-2:0], pico};
                ST_WE:    r_we    <= pico;
                ST_WDATA: begin
                    r_ishift <= {r_ishift[REG_WIDTH-3:0], pico};
                    if (w_cnt_last) r_addr <= r_addr + 8'd1;
                end
                ST_RDATA: if (w_cnt_last) r_addr <= r_addr + 8'd1;
                default: ;
            endcase
        end
    end

    sp3a_reg_bank #(
        .REG_WIDTH (REG_WIDTH),
        .NUM_REGS  (NUM_REGS)
    ) u_bank (
        .axi_clk  (axi_clk),
        .reset_b  (reset_b),
        .i_we     (w_commit),
        .i_wgroup (r_group),
        .i_waddr  (r_addr),
        .i_wdata  ({r_ishift, pico}),
        .i_sgroup (r_group),
        .i_saddr  (w_rd_addr),
        .o_sdata  (w_rd_data),
        .i_bgroup (bd_group),
        .i_baddr  (bd_addr),
        .o_bdata  (bd_rdata)
    );

    assign poci        = r_oshift[REG_WIDTH-1];
    assign wr_strobe   = r_wr_strobe;
    assign frame_done  = r_frame_done;
    assign frame_abort = r_frame_abort;

endmodule

// File: tb/tb_spi_peripheral_sp3a_model.sv
// Randomised scoreboard bench for the SP3A SPI responder: the stimulus side
// predicts per-cycle outputs from a register-array model, a monitor compares.
module tb_spi_peripheral_sp3a_model;

    logic        axi_clk = 1'b0;
    logic        reset_b;
    logic        cs_b;
    logic        pico;
    logic        poci;
    logic [1:0]  bd_group;
    logic [7:0]  bd_addr;
    logic [31:0] bd_rdata;
    logic        wr_strobe;
    logic        frame_done;
    logic        frame_abort;

    spi_peripheral_sp3a_model #(.REG_WIDTH(32), .NUM_REGS(16)) dut (
        .axi_clk     (axi_clk),
        .reset_b     (reset_b),
        .cs_b        (cs_b),
        .pico        (pico),
        .poci        (poci),
        .bd_group    (bd_group),
        .bd_addr     (bd_addr),
        .bd_rdata    (bd_rdata),
        .wr_strobe   (wr_strobe),
        .frame_done  (frame_done),
        .frame_abort (frame_abort)
    );

    always #5 axi_clk = ~axi_clk;

    localparam int K_POCI   = 0;
    localparam int K_STROBE = 1;
    localparam int K_DONE   = 2;
    localparam int K_ABORT  = 3;

    typedef struct {
        int   cyc;
        int   kind;
        logic val;
    } ev_t;

    ev_t         q[$];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] mem [4][16];
    logic [31:0] wq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] mrd(input logic [1:0] g, input logic [7:0] a);
        if (a < 8'd16) return mem[g][a[3:0]];
        return 32'h0;
    endfunction

    task automatic push(input int e, input int kind, input logic val);
        ev_t ev;
        ev.cyc  = e;
        ev.kind = kind;
        ev.val  = val;
        q.push_back(ev);
    endtask

    task automatic drive_edge(input logic cs, input logic d, output int e);
        @(negedge axi_clk);
        cs_b = cs;
        pico = d;
        e    = cyc + 1;
    endtask

    task automatic bd_check(input string name, input logic [1:0] g, input logic [7:0] a);
        bd_group = g;
        bd_addr  = a;
        #1;
        chk(name, bd_rdata, mrd(g, a));
    endtask

    // Drives one frame and records the outputs it must produce, keyed by edge.
    task automatic do_frame(input bit we, input logic [7:0] addr, input logic [1:0] grp,
                            input int hdr_bits, input int nbits, input bit no_end);
        logic [13:0] hdr;
        logic [31:0] w;
        logic [7:0]  a;
        int          e;
        hdr = {2'($urandom), addr, grp, we, 1'($urandom)};
        for (int i = 0; i < hdr_bits; i++) begin
            drive_edge(1'b0, hdr[13-i], e);
            if (i == 13 && !we) begin
                w = mrd(grp, addr);
                push(e, K_POCI, w[31]);
            end
        end
        if (hdr_bits < 14) begin
            drive_edge(1'b1, 1'($urandom), e);
            push(e, K_ABORT, 1'b1);
            return;
        end
        if (we) begin
            for (int i = 0; i < nbits; i++) begin
                w = wq[i/32];
                drive_edge(1'b0, w[31 - (i % 32)], e);
                if ((i % 32) == 31) begin
                    a = addr + 8'(i / 32);
                    if (a < 8'd16) begin
                        mem[grp][a[3:0]] = w;
                        push(e, K_STROBE, 1'b1);
                    end
                end
            end
        end else begin
            for (int j = 1; j <= nbits; j++) begin
                drive_edge(1'b0, 1'($urandom), e);
                w = mrd(grp, addr + 8'(j / 32));
                push(e, K_POCI, w[31 - (j % 32)]);
            end
        end
        if (no_end) return;
        drive_edge(1'b1, 1'($urandom), e);
        push(e, (we && (nbits % 32) != 0) ? K_ABORT : K_DONE, 1'b1);
    endtask

    task automatic apply_reset();
        @(negedge axi_clk);
        reset_b = 1'b0;
        cs_b    = 1'b1;
        q.delete();
        #1;
        chk("rst_poci", 32'(poci), 32'h0);
        chk("rst_wr_strobe", 32'(wr_strobe), 32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        chk("rst_frame_abort", 32'(frame_abort), 32'h0);
        for (int g = 0; g < 4; g++)
            for (int r = 0; r < 16; r++)
                mem[g][r] = 32'h0;
        for (int g = 0; g < 4; g++)
            for (int r = 0; r < 16; r++) begin
                bd_group = 2'(g);
                bd_addr  = 8'(r);
                #1;
                chk("rst_bd", bd_rdata, 32'h0);
            end
        @(negedge axi_clk);
        reset_b = 1'b1;
    endtask

    // Monitor: compares every output every cycle; absent events mean 0.
    initial begin
        ev_t  ev;
        logic exp_p, exp_s, exp_d, exp_a;
        forever begin
            @(posedge axi_clk);
            cyc++;
            #1;
            exp_p = 1'b0;
            exp_s = 1'b0;
            exp_d = 1'b0;
            exp_a = 1'b0;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                ev = q.pop_front();
                case (ev.kind)
                    K_POCI:   exp_p = ev.val;
                    K_STROBE: exp_s = ev.val;
                    K_DONE:   exp_d = ev.val;
                    default:  exp_a = ev.val;
                endcase
            end
            if (reset_b) begin
                chk("poci", 32'(poci), 32'(exp_p));
                chk("wr_strobe", 32'(wr_strobe), 32'(exp_s));
                chk("frame_done", 32'(frame_done), 32'(exp_d));
                chk("frame_abort", 32'(frame_abort), 32'(exp_a));
            end
        end
    end

    initial begin
        #5_000_000;
        miscompares++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        int          e;
        int          n;
        bit          we;
        logic [7:0]  addr;
        logic [1:0]  grp;
        int          hb;
        reset_b  = 1'b0;
        cs_b     = 1'b1;
        pico     = 1'b0;
        bd_group = 2'd0;
        bd_addr  = 8'd0;
        apply_reset();
        drive_edge(1'b1, 1'b0, e);

        wq.delete(); wq.push_back(32'hDEADBEEF);
        do_frame(1'b1, 8'h05, 2'd1, 14, 32, 1'b0);
        bd_group = 2'd1; bd_addr = 8'h05; #1;
        chk("bd_g1_a05", bd_rdata, 32'hDEADBEEF);

        do_frame(1'b0, 8'h05, 2'd1, 14, 32, 1'b0);

        wq.delete(); wq.push_back(32'h11111111); wq.push_back(32'h22222222);
        do_frame(1'b1, 8'h0F, 2'd2, 14, 64, 1'b0);
        bd_group = 2'd2; bd_addr = 8'h0F; #1;
        chk("bd_g2_a0f", bd_rdata, 32'h11111111);
        bd_check("bd_g2_a10", 2'd2, 8'h10);

        wq.delete(); wq.push_back(32'h0BADF00D);
        do_frame(1'b1, 8'h05, 2'd1, 14, 20, 1'b0);
        bd_group = 2'd1; bd_addr = 8'h05; #1;
        chk("bd_partial_keep", bd_rdata, 32'hDEADBEEF);

        do_frame(1'b1, 8'h03, 2'd3, 6, 0, 1'b0);
        wq.delete(); wq.push_back(32'hA5C3_0F96);
        do_frame(1'b1, 8'h03, 2'd3, 14, 32, 1'b0);
        bd_group = 2'd3; bd_addr = 8'h03; #1;
        chk("bd_g3_a03", bd_rdata, 32'hA5C30F96);

        wq.delete(); wq.push_back(32'h1); wq.push_back(32'h2); wq.push_back(32'h3);
        do_frame(1'b1, 8'hFE, 2'd0, 14, 96, 1'b0);
        bd_check("bd_wrap_g0_a00", 2'd0, 8'h00);
        do_frame(1'b0, 8'hFF, 2'd0, 14, 40, 1'b0);

        for (int f = 0; f < 40; f++) begin
            we   = 1'($urandom);
            grp  = 2'($urandom);
            n    = $urandom_range(0, 9);
            addr = (n < 7) ? 8'($urandom_range(0, 19)) : (n < 8) ? 8'hFE : 8'($urandom);
            hb   = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 13) : 14;
            if (we) begin
                n = 32 * $urandom_range(0, 3);
                if ($urandom_range(0, 3) == 0) n += $urandom_range(1, 31);
                wq.delete();
                for (int k = 0; k <= n / 32; k++) wq.push_back($urandom);
            end else begin
                n = $urandom_range(0, 80);
            end
            do_frame(we, addr, grp, hb, n, 1'b0);
            bd_check("bd_random", 2'($urandom), 8'($urandom_range(0, 17)));
            for (int g = 0; g < $urandom_range(0, 2); g++) drive_edge(1'b1, 1'($urandom), e);
        end

        wq.delete(); wq.push_back(32'hFFFFFFFF);
        do_frame(1'b1, 8'h05, 2'd1, 14, 32, 1'b0);
        do_frame(1'b0, 8'h05, 2'd1, 14, 10, 1'b1);
        apply_reset();
        do_frame(1'b0, 8'h05, 2'd1, 14, 32, 1'b0);

        for (int i = 0; i < 4; i++) drive_edge(1'b1, 1'b0, e);
        chk("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
